// File: rtl/sound_cmd_sender.sv
// Main-CPU side sender for the sound-board command latch: queues command bytes and
// hands them to the board one at a time with data setup, an MCODE strobe and MS handshake.
module sound_cmd_sender #(
    parameter int DEPTH        = 8,
    parameter int SETUP_CYCLES = 2,
    parameter int ACK_TIMEOUT  = 16,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          RESETn,
    input  logic          pause,
    input  logic          cmd_wr,
    input  logic [7:0]    cmd_din,
    input  logic          flush,
    input  logic          err_clr,
    input  logic          MS,
    output logic [7:0]    snd_data,
    output logic          MCODE,
    output logic [CW-1:0] fifo_count,
    output logic          fifo_full,
    output logic          busy,
    output logic          overflow,
    output logic          ack_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
    // The strobe clock itself counts toward the timeout, so WACK needs two fewer ticks.
    localparam logic [7:0] TO_LAST = (ACK_TIMEOUT > 1) ? 8'(ACK_TIMEOUT - 2) : 8'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WACK,
        S_WCLR
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    scnt, scnt_nxt;
    logic [7:0]    tcnt, tcnt_nxt;
    logic          mcode_nxt;
    logic          ack_set;
    logic          push, pop;
    logic [CW-1:0] count_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    mem [DEPTH];

    // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        push      = cmd_wr && !fifo_full;
        pop       = (state == S_IDLE) && !pause && (fifo_count != '0) && !MS;
        state_nxt = state;
        scnt_nxt  = scnt;
        tcnt_nxt  = tcnt;
        mcode_nxt = 1'b0;
        ack_set   = 1'b0;
        if (!pause) begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state_nxt = S_SETUP;
                        scnt_nxt  = '0;
                    end
                end
                S_SETUP: begin
                    if (scnt == SETUP_LAST) begin
                        state_nxt = S_STROBE;
                        mcode_nxt = 1'b1;
                    end else begin
                        scnt_nxt = scnt + 4'd1;
                    end
                end
                S_STROBE: begin
                    state_nxt = S_WACK;
                    tcnt_nxt  = '0;
                end
                S_WACK: begin
                    if (MS) begin
                        state_nxt = S_WCLR;
                    end else if (tcnt == TO_LAST) begin
                        ack_set   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        tcnt_nxt = tcnt + 8'd1;
                    end
                end
                S_WCLR: begin
                    if (!MS) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end

        if (flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = fifo_count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state      <= S_IDLE;
            scnt       <= '0;
            tcnt       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            snd_data   <= 8'h00;
            MCODE      <= 1'b0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            ack_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            scnt       <= scnt_nxt;
            tcnt       <= tcnt_nxt;
            MCODE      <= mcode_nxt;
            fifo_count <= count_nxt;
            fifo_full  <= (count_nxt == CW'(DEPTH));
            busy       <= (state_nxt != S_IDLE) || (count_nxt != '0);
            wr_ptr     <= flush ? '0 : wr_ptr + AW'(push);
            rd_ptr     <= flush ? '0 : rd_ptr + AW'(pop);
            if (pop) snd_data <= mem[rd_ptr];

            if (cmd_wr && fifo_full) overflow <= 1'b1;
            else if (err_clr)        overflow <= 1'b0;

            if (ack_set)      ack_err <= 1'b1;
            else if (err_clr) ack_err <= 1'b0;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cmd_din;
    end

endmodule

// File: tb/tb_sound_cmd_sender.sv
// Directed bench for sound_cmd_sender with a small sound-board MS model and strobe logger.
module tb_sound_cmd_sender;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          RESETn;
    logic          pause, cmd_wr, flush, err_clr, MS;
    logic [7:0]    cmd_din;
    logic [7:0]    snd_data;
    logic          MCODE;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, busy, overflow, ack_err;

    int total = 0;
    int bad   = 0;

    logic       auto_ms = 1'b0;
    logic       ms_man  = 1'b0;
    logic       ms_model = 1'b0;
    int         hold = 0;
    int         strobes = 0;
    logic [7:0] rx_q [$];

    sound_cmd_sender #(.DEPTH(DEPTH), .SETUP_CYCLES(2), .ACK_TIMEOUT(16)) dut (
        .clk(clk), .RESETn(RESETn), .pause(pause), .cmd_wr(cmd_wr), .cmd_din(cmd_din),
        .flush(flush), .err_clr(err_clr), .MS(MS), .snd_data(snd_data), .MCODE(MCODE),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .busy(busy),
        .overflow(overflow), .ack_err(ack_err)
    );

    assign MS = auto_ms ? ms_model : ms_man;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sound board: MS rises the clock after MCODE and drops 20 clocks later.
    always @(posedge clk) begin
        if (MCODE) begin
            rx_q.push_back(snd_data);
            strobes++;
        end
        if (!auto_ms) begin
            ms_model <= 1'b0;
            hold     <= 0;
        end else if (MCODE) begin
            ms_model <= 1'b1;
            hold     <= 20;
        end else if (hold != 0) begin
            hold <= hold - 1;
            if (hold == 1) ms_model <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cmd(input logic [7:0] b);
        cmd_wr  = 1'b1;
        cmd_din = b;
        tick();
        cmd_wr  = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        total++; if (snd_data !== 8'h00) begin bad++; $display("FAIL reset_snd_data got=%h exp=00", snd_data); end
        total++; if (MCODE !== 1'b0) begin bad++; $display("FAIL reset_mcode got=%b exp=0", MCODE); end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL reset_ack_err got=%b exp=0", ack_err); end
    endtask

    task automatic test_single();
        bit ok;
        auto_ms = 1'b1;
        write_cmd(8'h5A);                          // after edge N
        total++; if (fifo_count !== CW'(1)) begin bad++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
        total++; if (snd_data !== 8'h00) begin bad++; $display("FAIL single_data_early got=%h exp=00", snd_data); end
        tick();                                    // N+1: pop
        total++; if (snd_data !== 8'h5A) begin bad++; $display("FAIL single_data got=%h exp=5a", snd_data); end
        total++; if (MCODE !== 1'b0) begin bad++; $display("FAIL single_mcode_n1 got=%b exp=0", MCODE); end
        tick();                                    // N+2
        total++; if (MCODE !== 1'b0) begin bad++; $display("FAIL single_mcode_n2 got=%b exp=0", MCODE); end
        tick();                                    // N+3: strobe clock
        total++; if (MCODE !== 1'b1) begin bad++; $display("FAIL single_mcode_n3 got=%b exp=1", MCODE); end
        tick();
        total++; if (MCODE !== 1'b0) begin bad++; $display("FAIL single_mcode_n4 got=%b exp=0", MCODE); end
        wait_idle(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_idle got=busy exp=idle"); end
        total++; if (strobes !== 1) begin bad++; $display("FAIL single_strobes got=%0d exp=1", strobes); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL single_ack_err got=%b exp=0", ack_err); end
    endtask

    task automatic test_burst();
        bit ok;
        auto_ms = 1'b0;
        ms_man  = 1'b1;
        rx_q.delete();
        strobes = 0;
        for (int i = 1; i <= 8; i++) write_cmd(8'(i));
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL burst_full got=%b exp=1", fifo_full); end
        total++; if (fifo_count !== CW'(8)) begin bad++; $display("FAIL burst_count got=%0d exp=8", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL burst_ovf_early got=%b exp=0", overflow); end
        write_cmd(8'h09);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL burst_overflow got=%b exp=1", overflow); end
        total++; if (fifo_count !== CW'(8)) begin bad++; $display("FAIL burst_count_ovf got=%0d exp=8", fifo_count); end
        ms_man  = 1'b0;
        auto_ms = 1'b1;
        wait_idle(1500, ok);
        total++; if (!ok) begin bad++; $display("FAIL burst_idle got=busy exp=idle"); end
        total++; if (strobes !== 8) begin bad++; $display("FAIL burst_strobes got=%0d exp=8", strobes); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] got;
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            total++; if (got !== 8'(i + 1)) begin bad++; $display("FAIL burst_order[%0d] got=%h exp=%h", i, got, 8'(i + 1)); end
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL burst_err_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_busy_gate();
        bit ok;
        int s0;
        s0 = strobes;
        auto_ms = 1'b0;
        ms_man  = 1'b1;
        write_cmd(8'h33);
        repeat (20) tick();
        total++; if (strobes !== s0) begin bad++; $display("FAIL gate_no_strobe got=%0d exp=%0d", strobes, s0); end
        total++; if (fifo_count !== CW'(1)) begin bad++; $display("FAIL gate_count got=%0d exp=1", fifo_count); end
        total++; if (snd_data !== 8'h08) begin bad++; $display("FAIL gate_data_held got=%h exp=08", snd_data); end
        ms_man  = 1'b0;
        auto_ms = 1'b1;
        tick();                                    // pop edge P
        total++; if (snd_data !== 8'h33) begin bad++; $display("FAIL gate_pop got=%h exp=33", snd_data); end
        tick();
        total++; if (MCODE !== 1'b0) begin bad++; $display("FAIL gate_mcode_p1 got=%b exp=0", MCODE); end
        tick();
        total++; if (MCODE !== 1'b1) begin bad++; $display("FAIL gate_mcode_p2 got=%b exp=1", MCODE); end
        wait_idle(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL gate_idle got=busy exp=idle"); end
    endtask

    task automatic test_timeout();
        bit found;
        auto_ms = 1'b0;
        ms_man  = 1'b0;
        write_cmd(8'h77);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (MCODE === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL timeout_strobe got=none exp=mcode"); end
        repeat (15) tick();
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b exp=0", ack_err); end
        tick();
        total++; if (ack_err !== 1'b1) begin bad++; $display("FAIL timeout_ack_err got=%b exp=1", ack_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle got=%b exp=0", busy); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL timeout_clr got=%b exp=0", ack_err); end
    endtask

    task automatic test_flush_pause();
        bit ok, found;
        int s0;
        s0 = strobes;
        auto_ms = 1'b1;
        write_cmd(8'hA1);                          // N
        write_cmd(8'hA2);                          // N+1: A1 popped into SETUP
        pause = 1'b1;
        write_cmd(8'hA3);                          // pushed while paused
        total++; if (fifo_count !== CW'(2)) begin bad++; $display("FAIL pause_count got=%0d exp=2", fifo_count); end
        total++; if (snd_data !== 8'hA1) begin bad++; $display("FAIL pause_data got=%h exp=a1", snd_data); end
        repeat (5) tick();
        total++; if (strobes !== s0) begin bad++; $display("FAIL pause_frozen got=%0d exp=%0d", strobes, s0); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL flush_count got=%0d exp=0", fifo_count); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_inflight got=%b exp=1", busy); end
        pause = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (MCODE === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        total++; if (!found) begin bad++; $display("FAIL pause_resume got=none exp=mcode"); end
        total++; if (snd_data !== 8'hA1) begin bad++; $display("FAIL pause_strobe_data got=%h exp=a1", snd_data); end
        wait_idle(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL pause_idle got=busy exp=idle"); end
        total++; if (strobes !== s0 + 1) begin bad++; $display("FAIL pause_strobes got=%0d exp=%0d", strobes, s0 + 1); end
        cmd_wr  = 1'b1;
        cmd_din = 8'hEE;
        flush   = 1'b1;
        tick();
        cmd_wr = 1'b0;
        flush  = 1'b0;
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL flush_wr_count got=%0d exp=0", fifo_count); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_wr_busy got=%b exp=0", busy); end
        total++; if (snd_data !== 8'hA1) begin bad++; $display("FAIL flush_wr_data got=%h exp=a1", snd_data); end
    endtask

    task automatic test_reset_mid();
        bit ok, found;
        auto_ms = 1'b1;
        write_cmd(8'hC3);
        write_cmd(8'hC4);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (MCODE === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        total++; if (!found) begin bad++; $display("FAIL rst_mid_strobe got=none exp=mcode"); end
        #2 RESETn = 1'b0;
        #1;
        total++; if (MCODE !== 1'b0) begin bad++; $display("FAIL rst_mid_mcode got=%b exp=0", MCODE); end
        total++; if (snd_data !== 8'h00) begin bad++; $display("FAIL rst_mid_data got=%h exp=00", snd_data); end
        total++; if (fifo_count !== '0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", fifo_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_mid_overflow got=%b exp=0", overflow); end
        total++; if (ack_err !== 1'b0) begin bad++; $display("FAIL rst_mid_ack_err got=%b exp=0", ack_err); end
        #2 RESETn = 1'b1;
        tick();
        write_cmd(8'h3C);
        wait_idle(100, ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_mid_idle got=busy exp=idle"); end
        total++; if (rx_q.size() == 0 || rx_q[rx_q.size() - 1] !== 8'h3C) begin
            bad++; $display("FAIL rst_mid_after got=%h exp=3c", (rx_q.size() == 0) ? 8'hxx : rx_q[rx_q.size() - 1]);
        end
    endtask

    initial begin
        RESETn  = 1'b0;
        pause   = 1'b0;
        cmd_wr  = 1'b0;
        cmd_din = 8'h00;
        flush   = 1'b0;
        err_clr = 1'b0;
        #12;
        test_reset();
        RESETn = 1'b1;
        tick();
        tick();
        test_single();
        test_burst();
        test_busy_gate();
        test_timeout();
        test_flush_pause();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sound_cmd_sender.md
# sound_cmd_sender

Main-CPU-side transmitter for the sound-board command latch. It queues 8-bit sound commands written by the main CPU and presents each one on the sound data bus with the required setup time. It then issues a one-clock MCODE strobe and tracks the board's MS busy flag, so that a command is never overwritten before the sound CPU has acknowledged it. The block sits between the main CPU write decode and the sound board's `data_in`/`MCODE`/`MS` pins.

## Interface
Parameters:
- DEPTH, 8, command FIFO depth; power of two, 2..64.
- SETUP_CYCLES, 2, clocks `snd_data` is held stable before MCODE; legal range 1..15. The sound board registers `data_in` one clock before latching, so the minimum is 1.
- ACK_TIMEOUT, 16, clocks to wait for MS to rise after the strobe before flagging an error; legal range 1..255.

Ports:
- clk  in  1  system clock (53.6 MHz domain, same as the sound board).
- RESETn  in  1  asynchronous, active-low reset.
- pause  in  1  when high, the FSM and setup/timeout counters freeze; FIFO pushes are still accepted.
- cmd_wr  in  1  single-clock write strobe from the main CPU.
- cmd_din  in  8  command byte, sampled when `cmd_wr`=1.
- flush  in  1  single-clock; empties the FIFO; does not abort an in-flight command.
- err_clr  in  1  single-clock; clears `overflow` and `ack_err`.
- MS  in  1  sound board busy status; 1 = command latched and not yet acknowledged.
- snd_data  out  8  command byte driven to the sound board `data_in`.
- MCODE  out  1  one-clock latch strobe to the sound board.
- fifo_count  out  $clog2(DEPTH+1)  number of queued commands.
- fifo_full  out  1  fifo_count == DEPTH.
- busy  out  1  high while the FSM is not in IDLE or the FIFO is non-empty.
- overflow  out  1  sticky; set by a push while full.
- ack_err  out  1  sticky; set when MS did not rise within ACK_TIMEOUT.

## Operation
- FIFO: circular buffer with rd/wr pointers plus count.
  - Push when `cmd_wr` & !fifo_full.
  - Push while full is dropped and sets `overflow`.
  - A push and a pop in the same clock leave the count unchanged.
  - A push and `flush` in the same clock: `flush` wins, the FIFO ends empty, and the pushed byte is lost.
- FSM states:
  - IDLE: if the FIFO is non-empty and MS=0, pop the head into `snd_data` and go to SETUP with the counter cleared. If MS=1, stay in IDLE; the board is still busy from another source.
  - SETUP: count SETUP_CYCLES clocks, then go to STROBE.
  - STROBE: MCODE=1 for exactly one clock, then go to WACK with the timeout counter cleared.
  - WACK: on MS=1, go to WCLR. After ACK_TIMEOUT clocks with no MS rise, set `ack_err` and go to IDLE.
  - WCLR: wait for MS=0, then go to IDLE. There is no timeout here because the sound CPU may legitimately hold busy.
- `snd_data` holds its last value in every state; it changes only on a pop.
- `pause`=1 holds the state and all counters. If `pause` asserts during STROBE, MCODE stays 1 only for the one clock already in progress. The pause takes effect from the next state.
- If `err_clr` and a new error event occur in the same clock, the set wins.

## Timing
- Reset values: `snd_data`=0x00, MCODE=0, fifo_count=0, fifo_full=0, busy=0, overflow=0, ack_err=0, state IDLE, pointers 0.
- Reset is asynchronous. Deasserting it mid-transaction returns the block to IDLE with the FIFO empty. MCODE must never glitch high on reset.
- Push visibility: a command written at clock N is visible in fifo_count at N+1. With the FIFO empty, MS=0 and no pause, that command is popped at N+1 and `snd_data` is updated at N+2.
- MCODE rises SETUP_CYCLES clocks after `snd_data` changes. With the default setup, MCODE is high at N+4, counting from the write at N.
- Minimum spacing between strobes is SETUP_CYCLES + 1 (STROBE) + WACK time + WCLR time + 1 (IDLE), plus the MS round trip.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
- Single command: reset, write 0x5A at clock 10 with MS tied to a model (rises 1 clock after MCODE, falls 20 clocks later).
  - Expect `snd_data`=0x5A at clock 12 and MCODE high only at clock 14.
  - Expect busy=0 after MS falls.
- Burst and ordering: write 0x01..0x08 back-to-back (DEPTH=8), then write 0x09.
  - Expect fifo_full=1 and overflow=1.
  - Expect the sound model to receive 0x01..0x08 in order and never 0x09.
  - Expect exactly one MCODE per command.
- Busy gating: hold MS=1 from reset and write 0x33.
  - Expect no MCODE while MS=1.
  - Release MS at clock 50; expect MCODE at clock 51+SETUP_CYCLES+1, counting from the pop at 51.
- Ack timeout: the model never raises MS; write 0x77.
  - Expect ack_err=1 exactly ACK_TIMEOUT clocks after the MCODE clock, and the FSM back in IDLE.
  - Pulse err_clr; expect ack_err=0.
- Flush and pause:
  - Queue 3 commands, assert pause during SETUP of the first, then pulse flush.
  - Expect fifo_count=0, and the first command still strobed after pause deasserts.
  - Also assert flush together with cmd_wr; expect an empty FIFO.
- Async reset mid-operation: assert RESETn low during STROBE (between clock edges).
  - Expect MCODE, `snd_data`, fifo_count, overflow and ack_err to be 0 immediately.
  - After release, a new write completes normally.
